// File: rtl/mips_bus_pkg.sv
// Shared Avalon bus definitions for the MIPS core: arbiter states, port ids,
// byte-lane width and the word returned to a requester whose transaction timed out.
package mips_bus_pkg;

    localparam int                  AVL_BE_W      = 4;
    localparam logic [AVL_BE_W-1:0] AVL_BE_ALL    = '1;
    localparam logic [31:0]         BAD_READ_WORD = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_I = 2'd1,
        ARB_GRANT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } arb_port_t;

    // On contention the port that did not own the bus last time goes first.
    function automatic arb_state_t arb_pick(
        input logic      req_i,
        input logic      req_d,
        input arb_port_t last_grant
    );
        arb_state_t pick;
        pick = ARB_IDLE;
        if (req_i && req_d) begin
            pick = (last_grant == PORT_D) ? ARB_GRANT_I : ARB_GRANT_D;
        end else if (req_i) begin
            pick = ARB_GRANT_I;
        end else if (req_d) begin
            pick = ARB_GRANT_D;
        end
        return pick;
    endfunction

endpackage

// File: rtl/avalon_mem_arbiter.sv
// Two-to-one round-robin arbiter putting instruction fetch and load/store onto one
// Avalon-MM RAM bus. Optional stall watchdog enabled by defining ARB_TIMEOUT_EN.
module avalon_mem_arbiter
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   i_address,
    input  logic                i_read,
    output logic                i_waitrequest,
    output logic [DATA_W-1:0]   i_readdata,

    input  logic [ADDR_W-1:0]   d_address,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [DATA_W-1:0]   d_writedata,
    input  logic [AVL_BE_W-1:0] d_byteenable,
    output logic                d_waitrequest,
    output logic [DATA_W-1:0]   d_readdata,

    output logic [ADDR_W-1:0]   m_address,
    output logic                m_read,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic [AVL_BE_W-1:0] m_byteenable,
    input  logic                m_waitrequest,
    input  logic [DATA_W-1:0]   m_readdata,

    output logic                grant_d,
    output logic                timeout_err
);

    arb_state_t  state_q, state_d;
    arb_port_t   last_grant_q, last_grant_d;

    logic        req_i, req_d;
    logic        req_granted;
    logic        stall;
    logic        timeout_hit;
    logic        finish;
    logic [DATA_W-1:0] resp_word;

    assign req_i = i_read;
    assign req_d = d_read | d_write;

    assign req_granted = (state_q == ARB_GRANT_I) ? req_i :
                         (state_q == ARB_GRANT_D) ? req_d : 1'b0;
    assign stall       = req_granted & m_waitrequest;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] stall_cnt_q;

    // The expiring stall cycle itself is the one that gets the forced completion.
    assign timeout_hit = stall && (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (state_d == ARB_IDLE) begin
            stall_cnt_q <= '0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign finish      = (req_granted & ~m_waitrequest) | timeout_hit;
    assign resp_word   = timeout_hit ? DATA_W'(BAD_READ_WORD) : m_readdata;
    assign grant_d     = (state_q == ARB_GRANT_D);
    assign timeout_err = timeout_hit;

    always_comb begin
        // NOTE: every output and next-state value is defaulted first so no path infers a latch.
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        m_address     = '0;
        m_read        = 1'b0;
        m_write       = 1'b0;
        m_writedata   = '0;
        m_byteenable  = '0;
        i_waitrequest = 1'b1;
        i_readdata    = '0;
        d_waitrequest = 1'b1;
        d_readdata    = '0;

        case (state_q)
            ARB_IDLE: begin
                state_d = arb_pick(req_i, req_d, last_grant_q);
            end

            ARB_GRANT_I: begin
                m_address    = i_address;
                m_byteenable = AVL_BE_ALL;
                m_read       = req_i & ~timeout_hit;
                if (!req_i) begin
                    // Requester gave up: release the bus without crediting it a turn.
                    state_d = ARB_IDLE;
                end else if (finish) begin
                    i_waitrequest = 1'b0;
                    i_readdata    = resp_word;
                    state_d       = ARB_IDLE;
                    last_grant_d  = PORT_I;
                end
            end

            ARB_GRANT_D: begin
                m_address    = d_address;
                m_writedata  = d_writedata;
                m_byteenable = d_byteenable;
                m_write      = d_write & ~timeout_hit;
                m_read       = d_read & ~d_write & ~timeout_hit;
                if (!req_d) begin
                    state_d = ARB_IDLE;
                end else if (finish) begin
                    d_waitrequest = 1'b0;
                    d_readdata    = resp_word;
                    state_d       = ARB_IDLE;
                    last_grant_d  = PORT_D;
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= PORT_D;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Self-checking bench for avalon_mem_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level model of the arbiter.
module tb_avalon_mem_arbiter;

    localparam int TO = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_address, d_address, d_writedata, m_address, m_writedata, m_readdata;
    logic [31:0] i_readdata, d_readdata;
    logic [3:0]  d_byteenable, m_byteenable;
    logic        i_read, d_read, d_write, m_waitrequest;
    logic        i_waitrequest, d_waitrequest, m_read, m_write, grant_d, timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avalon_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(rst_n),
        .i_address(i_address), .i_read(i_read), .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
        .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_writedata(d_writedata),
        .d_byteenable(d_byteenable), .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
        .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
        .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
        .grant_d(grant_d), .timeout_err(timeout_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // RAM slave: zero-latency read, byte-lane writes on accepted write cycles.
    logic [31:0] ram [0:255];
    initial begin : ram_proc
        for (int i = 0; i < 256; i++) ram[i] = 32'hC0DE_0000 | 32'(i);
        ram[1] = 32'h2402_0010;
        ram[3] = 32'h8C0A_0004;
        forever begin
            @(posedge clk);
            if (rst_n && m_write && !m_waitrequest)
                for (int b = 0; b < 4; b++)
                    if (m_byteenable[b]) ram[m_address[9:2]][8*b +: 8] <= m_writedata[8*b +: 8];
        end
    end
    assign m_readdata = ram[m_address[9:2]];

    // Model: who owns the bus (0 none, 1 fetch, 2 data), who won last, stall cycles so far.
    int mdl_owner = 0, nxt_owner = 0;
    bit mdl_last_d = 1'b1, nxt_last_d = 1'b1;
    int mdl_stalls = 0, nxt_stalls = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_owner  <= 0;
            mdl_last_d <= 1'b1;
            mdl_stalls <= 0;
        end else begin
            mdl_owner  <= nxt_owner;
            mdl_last_d <= nxt_last_d;
            mdl_stalls <= nxt_stalls;
        end
    end

    always @(negedge clk) begin : compare
        logic [31:0] e_addr, e_wd, e_ird, e_drd;
        logic [3:0]  e_be;
        logic        e_rd, e_wr, e_iw, e_dw, e_gd, e_te, tout, req;
        int          n_owner, n_stalls;
        bit          n_last_d;
        e_addr = '0; e_wd = '0; e_ird = '0; e_drd = '0; e_be = '0;
        e_rd = 1'b0; e_wr = 1'b0; e_iw = 1'b1; e_dw = 1'b1; e_gd = 1'b0; e_te = 1'b0;
        tout = 1'b0; req = 1'b0;
        n_owner = mdl_owner; n_last_d = mdl_last_d; n_stalls = mdl_stalls;
        if (rst_n) begin
            if (mdl_owner == 0) begin
                if (i_read && (d_read || d_write)) n_owner = mdl_last_d ? 1 : 2;
                else if (i_read)                   n_owner = 1;
                else if (d_read || d_write)        n_owner = 2;
            end else begin
                req  = (mdl_owner == 1) ? i_read : (d_read || d_write);
                tout = TO_EN && req && m_waitrequest && (mdl_stalls == TO - 1);
                if (mdl_owner == 1) begin
                    e_addr = i_address; e_be = 4'hF; e_rd = req && !tout;
                end else begin
                    e_gd = 1'b1; e_addr = d_address; e_wd = d_writedata; e_be = d_byteenable;
                    e_wr = d_write && !tout;
                    e_rd = d_read && !d_write && !tout;
                end
                if (!req) begin
                    n_owner = 0; n_stalls = 0;
                end else if (!m_waitrequest || tout) begin
                    if (mdl_owner == 1) begin
                        e_iw = 1'b0; e_ird = tout ? 32'hDEADBEEF : m_readdata;
                    end else begin
                        e_dw = 1'b0; e_drd = tout ? 32'hDEADBEEF : m_readdata;
                    end
                    e_te = tout; n_owner = 0; n_last_d = (mdl_owner == 2); n_stalls = 0;
                end else begin
                    n_stalls = mdl_stalls + 1;
                end
            end
        end
        nxt_owner  <= n_owner;
        nxt_last_d <= n_last_d;
        nxt_stalls <= n_stalls;
        check("m_address", m_address, e_addr);
        check("m_read", m_read, e_rd);
        check("m_write", m_write, e_wr);
        check("m_writedata", m_writedata, e_wd);
        check("m_byteenable", m_byteenable, e_be);
        check("i_waitrequest", i_waitrequest, e_iw);
        check("d_waitrequest", d_waitrequest, e_dw);
        check("i_readdata", i_readdata, e_ird);
        check("d_readdata", d_readdata, e_drd);
        check("grant_d", grant_d, e_gd);
        check("timeout_err", timeout_err, e_te);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0; d_byteenable = '0;
        m_waitrequest = 1'b0;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        clear_inputs();
        step();
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        return {22'd0, 8'($urandom_range(255)), 2'b00};
    endfunction

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int   seq [6];
    int   n_seq, pulses, stuck;
    logic iw, dw;
    int   r;

    initial begin : stim
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        check("rst_m_read", m_read, 1'b0);
        check("rst_m_write", m_write, 1'b0);
        check("rst_m_address", m_address, 32'h0);
        check("rst_m_byteenable", m_byteenable, 4'h0);
        check("rst_i_wait", i_waitrequest, 1'b1);
        check("rst_d_wait", d_waitrequest, 1'b1);
        check("rst_grant_d", grant_d, 1'b0);
        check("rst_readdata", {i_readdata, d_readdata}, 64'h0);

        // Fetch only: granted in cycle 2, zero-latency readdata.
        step();
        rst_n = 1'b1; i_read = 1'b1; i_address = 32'h04;
        @(negedge clk);
        check("fo_c1_m_read", m_read, 1'b0);
        @(negedge clk);
        check("fo_c2_m_read", m_read, 1'b1);
        check("fo_c2_i_wait", i_waitrequest, 1'b0);
        check("fo_c2_i_readdata", i_readdata, 32'h2402_0010);
        check("fo_c2_grant_d", grant_d, 1'b0);
        step();
        i_read = 1'b0;
        @(negedge clk);
        check("fo_bubble_m_read", m_read, 1'b0);

        // Simultaneous after reset: fetch first, bubble, then the store.
        do_reset();
        i_read = 1'b1; i_address = 32'h08;
        d_write = 1'b1; d_address = 32'h100; d_writedata = 32'hE0; d_byteenable = 4'hF;
        @(negedge clk);
        @(negedge clk);
        check("sim_fetch_grant_d", grant_d, 1'b0);
        check("sim_fetch_addr", m_address, 32'h08);
        check("sim_fetch_i_wait", i_waitrequest, 1'b0);
        check("sim_fetch_d_wait", d_waitrequest, 1'b1);
        step();
        i_read = 1'b0;
        @(negedge clk);
        check("sim_bubble_m_write", m_write, 1'b0);
        @(negedge clk);
        check("sim_store_grant_d", grant_d, 1'b1);
        check("sim_store_m_write", m_write, 1'b1);
        check("sim_store_addr", m_address, 32'h100);
        check("sim_store_d_wait", d_waitrequest, 1'b0);
        step();
        d_write = 1'b0;
        @(negedge clk);
        check("sim_ram_0x100", ram[64], 32'hE0);

        // Back-to-back contention: grants must alternate starting with fetch.
        do_reset();
        i_read = 1'b1; i_address = 32'h10;
        d_read = 1'b1; d_address = 32'h20; d_byteenable = 4'hF;
        n_seq = 0;
        for (int k = 0; k < 40 && n_seq < 6; k++) begin
            @(negedge clk);
            if (!i_waitrequest)      begin seq[n_seq] = 0; n_seq++; end
            else if (!d_waitrequest) begin seq[n_seq] = 1; n_seq++; end
        end
        check("rr_count", n_seq, 6);
        for (int k = 0; k < 6; k++) check($sformatf("rr_grant%0d", k), seq[k], k % 2);
        step();
        clear_inputs();
        step();
        step();

        // RAM stall on a load: five stalled grant cycles, completion in the sixth.
        d_read = 1'b1; d_address = 32'h0C; d_byteenable = 4'hF; m_waitrequest = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_d_wait", d_waitrequest, 1'b1);
            check("stall_addr", m_address, 32'h0C);
            check("stall_i_wait", i_waitrequest, 1'b1);
        end
        step();
        m_waitrequest = 1'b0;
        @(negedge clk);
        check("stall_done_d_wait", d_waitrequest, 1'b0);
        check("stall_done_data", d_readdata, 32'h8C0A_0004);
        step();
        d_read = 1'b0;

        // Reset in the middle of a granted fetch.
        i_read = 1'b1; i_address = 32'h14; m_waitrequest = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mid_pre_m_read", m_read, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_m_read", m_read, 1'b0);
        check("mid_m_write", m_write, 1'b0);
        check("mid_waits", {i_waitrequest, d_waitrequest}, 2'b11);
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_after_idle_m_read", m_read, 1'b0);
        check("mid_after_idle_i_wait", i_waitrequest, 1'b1);
        step();
        m_waitrequest = 1'b0;
        @(negedge clk);
        step();
        i_read = 1'b0;

`ifdef ARB_TIMEOUT_EN
        // Stuck RAM: forced completion on the 8th stall cycle, then the data port.
        do_reset();
        i_read = 1'b1; i_address = 32'h18;
        d_read = 1'b1; d_address = 32'h1C; d_byteenable = 4'hF; m_waitrequest = 1'b1;
        @(negedge clk);
        pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k < 8) pulses += int'(timeout_err);
        end
        check("to_early_pulses", pulses, 0);
        check("to_err", timeout_err, 1'b1);
        check("to_i_wait", i_waitrequest, 1'b0);
        check("to_i_readdata", i_readdata, 32'hDEADBEEF);
        check("to_m_read", m_read, 1'b0);
        step();
        i_read = 1'b0;
        @(negedge clk);
        check("to_bubble_err", timeout_err, 1'b0);
        @(negedge clk);
        check("to_next_grant_d", grant_d, 1'b1);
        step();
        m_waitrequest = 1'b0;
        @(negedge clk);
        check("to_next_d_data", d_readdata, 32'hC0DE_0007);
        step();
        d_read = 1'b0;
`endif

        // Randomized traffic; requests are held while stalled, with rare abandons.
        stuck = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            iw = i_waitrequest;
            dw = d_waitrequest;
            step();
            if (!(i_read && iw) || $urandom_range(31) == 0) begin
                i_read    = 1'($urandom_range(1));
                i_address = rand_addr();
            end
            if (!((d_read || d_write) && dw) || $urandom_range(31) == 0) begin
                r            = int'($urandom_range(9));
                d_read       = (r < 4) || (r == 8);
                d_write      = (r >= 4 && r < 8) || (r == 8);
                d_address    = rand_addr();
                d_writedata  = $urandom;
                d_byteenable = 4'($urandom_range(15));
            end
            if (stuck > 0) begin
                m_waitrequest = 1'b1;
                stuck--;
            end else if ($urandom_range(63) == 0) begin
                stuck = int'($urandom_range(12, 9));
                m_waitrequest = 1'b1;
            end else begin
                m_waitrequest = ($urandom_range(3) == 0);
            end
        end

        step();
        clear_inputs();
        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/avalon_mem_arbiter.md
Name: avalon_mem_arbiter

Overview:
Two-to-one arbiter sharing the single Avalon memory-mapped bus to the RAM between the CPU instruction-fetch port and the data (load/store) port. Each requester sees a standard Avalon slave interface with its own waitrequest. The arbiter grants one requester at a time, holds the grant until that transaction completes, and routes readdata back. It sits between top_level_CPU's internal fetch/memory stages and the RAM.

Parameters:
ADDR_W, 32, address width on all ports
DATA_W, 32, data width on all ports
TIMEOUT_CYCLES, 1024, max waitrequest cycles per granted transaction (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
i_address  in  ADDR_W  fetch address
i_read  in  1  fetch read request
i_waitrequest  out  1  fetch stall
i_readdata  out  DATA_W  fetched word
d_address  in  ADDR_W  data address
d_read  in  1  load request
d_write  in  1  store request
d_writedata  in  DATA_W  store data
d_byteenable  in  4  store/load byte lanes
d_waitrequest  out  1  data stall
d_readdata  out  DATA_W  load data
m_address  out  ADDR_W  to RAM
m_read  out  1  to RAM
m_write  out  1  to RAM
m_writedata  out  DATA_W  to RAM
m_byteenable  out  4  to RAM
m_waitrequest  in  1  from RAM
m_readdata  in  DATA_W  from RAM
grant_d  out  1  1 = data port owns bus (status)
timeout_err  out  1  one-cycle pulse on timeout (tied 0 without ARB_TIMEOUT_EN)

Behaviour:
- Reset (reset low, async): state IDLE, last_grant = DATA, counter 0. Outputs: m_read=m_write=0, m_address/m_writedata=0, m_byteenable=0, i/d_waitrequest=1, grant_d=0, timeout_err=0, readdata outputs 0.
- States: IDLE, GRANT_I, GRANT_D (registered). req_i = i_read; req_d = d_read|d_write.
- IDLE: only one request -> grant it next cycle. Both -> grant the port not in last_grant (round-robin; after reset, fetch wins first). None -> stay. 1-cycle arbitration latency.
- GRANT_x: m_* driven combinationally from granted port; other port's waitrequest=1. Completion = (m_read|m_write) & !m_waitrequest; in that cycle granted port's waitrequest=0 and its readdata=m_readdata (zero-latency readdata). Next state IDLE; last_grant updated. Mandatory IDLE bubble prevents re-granting a still-high request.
- Requests must be held while waitrequest=1. If granted request drops before completion: abandon, m_read/m_write=0 same cycle, -> IDLE, last_grant unchanged.
- d_read & d_write together: write wins, m_read masked to 0.
- Non-granted port's readdata held at 0.
- Minimum transaction: 3 cycles request-to-completion with RAM waitrequest low (arbitrate, grant+complete, bubble shared).
- Reset mid-transaction: bus deasserted immediately, no completion reported.

Optional Feature:
ARB_TIMEOUT_EN: counter increments each GRANT cycle with m_waitrequest=1; on reaching TIMEOUT_CYCLES, force completion to requester (waitrequest=0, readdata=32'hDEADBEEF), pulse timeout_err for 1 cycle, drop m_read/m_write, -> IDLE. Counter clears on every exit from GRANT. Without macro: no counter, timeout_err constant 0, grant held indefinitely.

Decomposition:
- Shared package mips_bus_pkg: typedef enum arb_state_t {ARB_IDLE, ARB_GRANT_I, ARB_GRANT_D}; localparam BAD_READ_WORD = 32'hDEADBEEF; Avalon byteenable width constant.
- No sub-module needed; the optional timeout counter may be a small sub-module arb_timeout_counter (enable, clear, expired).

Test Plan:
- Fetch only: i_read=1, i_address=0x04, RAM word 0x24020010, waitrequest 0 -> m_read high cycle 2, i_waitrequest low cycle 2, i_readdata=0x24020010; grant_d=0.
- Simultaneous after reset: i_read to 0x08, d_write 0xE0 to 0x100, byteenable 4'hF -> fetch served first, then IDLE bubble, then write; RAM 0x100 reads 0xE0.
- Back-to-back contention: both requests held continuously for 6 transactions -> grants alternate I,D,I,D,I,D.
- RAM stall: m_waitrequest high 5 cycles during data load of 0x0C -> d_waitrequest high through stall, m_address stable 0x0C, completes on 6th cycle with correct data; i_waitrequest remains 1.
- Reset low mid-grant -> m_read/m_write 0 immediately, both waitrequests 1, state IDLE after release.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, m_waitrequest stuck 1 -> timeout_err pulses once at 8th stall cycle, i_readdata=0xDEADBEEF, arbiter then serves pending data request.
